// File: rtl/ro_puf_ctrl_if.sv
// Challenge/response link between the root-of-trust sequencer (master) and the RO-PUF controller (slave).
// Request side: start/abort/challenge. Response side: busy, single-cycle result strobe, held result and counts.
interface ro_puf_ctrl_if #(
    parameter int IDX_W = 3,
    parameter int CNT_W = 16
);
    logic             start;
    logic             abort;
    logic [IDX_W-1:0] chal_a;
    logic [IDX_W-1:0] chal_b;
    logic             busy;
    logic             resp_valid;
    logic             resp_bit;
    logic             resp_tie;
    logic             resp_err;
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    modport master (
        output start, abort, chal_a, chal_b,
        input  busy, resp_valid, resp_bit, resp_tie, resp_err, cnt_a, cnt_b
    );

    modport slave (
        input  start, abort, chal_a, chal_b,
        output busy, resp_valid, resp_bit, resp_tie, resp_err, cnt_a, cnt_b
    );
endinterface

// File: rtl/ro_puf_ctrl.sv
// RO-PUF pair sequencer: enable challenged pair, settle, count synchronized edges over a gate, compare to one bit.
// Latency SETTLE_CYC+GATE_CYC+1 cycles start->resp_valid (1 on bad challenge); start ignored while busy, abort idles next cycle.
module ro_puf_ctrl #(
    parameter int NUM_RO     = 8,
    parameter int IDX_W      = 3,
    parameter int CNT_W      = 16,
    parameter int SETTLE_CYC = 4,
    parameter int GATE_CYC   = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    ro_puf_ctrl_if.slave      bus,
    input  logic [NUM_RO-1:0] ro_out,
    output logic [NUM_RO-1:0] ro_en
);
    localparam int TMR_MAX = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam int NSEL    = 1 << IDX_W;
    localparam int IW1     = IDX_W + 1;
    localparam logic [IW1-1:0] NUM_LIM = IW1'(NUM_RO);

    typedef enum logic [2:0] {S_IDLE, S_SETTLE, S_COUNT, S_CMP, S_ERR} state_t;

    state_t            r_state, w_next;
    logic [TW-1:0]     r_tmr;
    logic [IDX_W-1:0]  r_a, r_b;
    logic [NUM_RO-1:0] r_sync1, r_sync2, r_prev, r_ro_en;
    logic [CNT_W-1:0]  r_cnt_a, r_cnt_b;
    logic              r_bit, r_tie, r_err;

    logic              w_chal_ok, w_tmr_done, w_gt, w_eq;
    logic [NUM_RO-1:0] w_edge, w_oh_a, w_oh_b;
    logic [NSEL-1:0]   w_edge_x;

    assign w_chal_ok = (bus.chal_a != bus.chal_b) &&
                       ({1'b0, bus.chal_a} < NUM_LIM) && ({1'b0, bus.chal_b} < NUM_LIM);
    assign w_oh_a    = NUM_RO'(1) << bus.chal_a;
    assign w_oh_b    = NUM_RO'(1) << bus.chal_b;
    assign w_tmr_done = (r_state == S_SETTLE) ? (r_tmr == TW'(SETTLE_CYC - 1))
                                              : (r_tmr == TW'(GATE_CYC - 1));
    // Every ring is synchronized so the selected bit is never muxed before the first flop.
    assign w_edge   = r_sync2 & ~r_prev;
    assign w_edge_x = NSEL'(w_edge);
    assign w_gt     = r_cnt_a > r_cnt_b;
    assign w_eq     = r_cnt_a == r_cnt_b;

    assign ro_en     = r_ro_en;
    assign bus.cnt_a = r_cnt_a;
    assign bus.cnt_b = r_cnt_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next         = r_state;
        bus.busy       = (r_state != S_IDLE);
        bus.resp_valid = 1'b0;
        bus.resp_bit   = r_bit;
        bus.resp_tie   = r_tie;
        bus.resp_err   = r_err;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.abort) w_next = w_chal_ok ? S_SETTLE : S_ERR;
            end
            S_SETTLE: begin
                if (bus.abort)       w_next = S_IDLE;
                else if (w_tmr_done) w_next = S_COUNT;
            end
            S_COUNT: begin
                if (bus.abort)       w_next = S_IDLE;
                else if (w_tmr_done) w_next = S_CMP;
            end
            S_CMP: begin
                w_next         = S_IDLE;
                bus.resp_valid = 1'b1;
                bus.resp_bit   = w_gt;
                bus.resp_tie   = w_eq;
                bus.resp_err   = 1'b0;
            end
            default: begin
                w_next         = S_IDLE;
                bus.resp_valid = 1'b1;
                bus.resp_bit   = 1'b0;
                bus.resp_tie   = 1'b0;
                bus.resp_err   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_prev  <= '0;
            r_tmr   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_ro_en <= '0;
            r_cnt_a <= '0;
            r_cnt_b <= '0;
            r_bit   <= 1'b0;
            r_tie   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_sync1 <= ro_out;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_tmr   <= (w_next == r_state) ? r_tmr + 1'b1 : '0;

            if (r_state == S_IDLE && w_next == S_SETTLE) begin
                r_a     <= bus.chal_a;
                r_b     <= bus.chal_b;
                r_cnt_a <= '0;
                r_cnt_b <= '0;
                r_ro_en <= w_oh_a | w_oh_b;
            end else if (w_next == S_IDLE || w_next == S_CMP) begin
                r_ro_en <= '0;
            end

            // Saturating counters: a ring faster than the gate can hold still compares correctly.
            if (r_state == S_COUNT) begin
                if (w_edge_x[r_a] && (r_cnt_a != '1)) r_cnt_a <= r_cnt_a + 1'b1;
                if (w_edge_x[r_b] && (r_cnt_b != '1)) r_cnt_b <= r_cnt_b + 1'b1;
            end

            if (r_state == S_CMP) begin
                r_bit <= w_gt;
                r_tie <= w_eq;
                r_err <= 1'b0;
            end else if (r_state == S_ERR) begin
                r_bit <= 1'b0;
                r_tie <= 1'b0;
                r_err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_ro_puf_ctrl.sv
// Bench for ro_puf_ctrl: clock-locked behavioural rings, directed scenarios plus randomized challenges vs a rate model.
// A second instance with 4-bit counters and a free-running clk/4 ring covers saturation.
module tb_ro_puf_ctrl;
    localparam int GATE = 64;
    localparam int SETL = 4;

    logic       core_clk = 1'b0;
    logic       arst_n   = 1'b0;
    logic [7:0] ro       = '0;
    logic [7:0] ro_en;
    logic [7:0] ro_en2;
    logic       ro_f     = 1'b0;
    int         fph      = 0;
    int         h  [8]   = '{default: 2};
    int         ph [8]   = '{default: 0};
    int         hset [4] = '{2, 3, 4, 8};
    int         n_chk    = 0;
    int         n_fail   = 0;

    always #5 core_clk = ~core_clk;

    ro_puf_ctrl_if #(.IDX_W(4), .CNT_W(16)) i1 ();
    ro_puf_ctrl_if #(.IDX_W(3), .CNT_W(4))  i2 ();

    ro_puf_ctrl #(.NUM_RO(8), .IDX_W(4), .CNT_W(16), .SETTLE_CYC(SETL), .GATE_CYC(GATE)) u_dut (
        .clk(core_clk), .rst_n(arst_n), .bus(i1.slave), .ro_out(ro), .ro_en(ro_en));

    ro_puf_ctrl #(.NUM_RO(8), .IDX_W(3), .CNT_W(4), .SETTLE_CYC(SETL), .GATE_CYC(GATE)) u_sat (
        .clk(core_clk), .rst_n(arst_n), .bus(i2.slave), .ro_out({8{ro_f}}), .ro_en(ro_en2));

    // Each enabled ring toggles every h[i] clock periods, phase-reset while disabled.
    always @(negedge core_clk) begin
        for (int i = 0; i < 8; i++) begin
            if (!ro_en[i]) begin
                ro[i] <= 1'b0;
                ph[i] <= 0;
            end else if (ph[i] + 1 >= h[i]) begin
                ro[i] <= ~ro[i];
                ph[i] <= 0;
            end else begin
                ph[i] <= ph[i] + 1;
            end
        end
        if (fph == 1) begin
            ro_f <= ~ro_f;
            fph  <= 0;
        end else begin
            fph <= fph + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", tag, act, exp);
        end
    endtask

    function automatic bit chal_ok(input logic [3:0] a, input logic [3:0] b);
        return (a != b) && (a < 4'd8) && (b < 4'd8);
    endfunction

    // Count expected within one edge of GATE / ring period.
    function automatic bit cnt_ok(input int cnt, input int hh);
        int d;
        d = cnt * 2 * hh - GATE;
        if (d < 0) d = -d;
        return d <= 2 * hh;
    endfunction

    // Called at the start of cycle 0 with the DUT idle; returns at the start of the cycle after busy falls.
    task automatic run_eval(input logic [3:0] a, input logic [3:0] b, input int abort_at, input bit hold,
                            input bit ok, output int rv_cyc, output int rv_cnt, output int busy_low,
                            output int en_bad, output logic rb, output logic rt, output logic re,
                            output logic [15:0] ca, output logic [15:0] cb);
        logic [7:0] oh;
        logic [7:0] exp_en;
        int         last;
        oh       = ok ? ((8'd1 << a[2:0]) | (8'd1 << b[2:0])) : 8'd0;
        last     = (abort_at > 0) ? abort_at : SETL + GATE;
        rv_cyc   = -1; rv_cnt = 0; busy_low = -1; en_bad = 0;
        rb = 1'b0; rt = 1'b0; re = 1'b0; ca = '0; cb = '0;
        i1.chal_a = a; i1.chal_b = b; i1.start = 1'b1;
        @(posedge core_clk); #1;
        if (!hold) i1.start = 1'b0;
        i1.chal_a = 4'($urandom_range(0, 15));
        i1.chal_b = 4'($urandom_range(0, 15));
        for (int c = 1; c <= 200; c++) begin
            if (c == abort_at) i1.abort = 1'b1;
            @(negedge core_clk);
            exp_en = (c <= last) ? oh : 8'd0;
            if (ro_en !== exp_en) en_bad++;
            if (i1.resp_valid) begin
                rv_cnt++;
                if (rv_cyc < 0) begin
                    rv_cyc = c; rb = i1.resp_bit; rt = i1.resp_tie; re = i1.resp_err;
                end
            end
            ca = i1.cnt_a; cb = i1.cnt_b;
            if (!i1.busy) begin
                busy_low = c;
                break;
            end
            @(posedge core_clk); #1;
            i1.abort = 1'b0;
        end
        @(posedge core_clk); #1;
        i1.abort = 1'b0;
    endtask

    task automatic check_eval(input string tag, input logic [3:0] a, input logic [3:0] b,
                              input int abort_at, input bit hold);
        int rv_cyc, rv_cnt, busy_low, en_bad;
        logic rb, rt, re;
        logic [15:0] ca, cb;
        bit ok;
        ok = chal_ok(a, b);
        run_eval(a, b, abort_at, hold, ok, rv_cyc, rv_cnt, busy_low, en_bad, rb, rt, re, ca, cb);
        chk({tag, "_ro_en"}, en_bad, 0);
        if (!ok) begin
            chk({tag, "_err_cyc"}, rv_cyc, 1);
            chk({tag, "_err_cnt"}, rv_cnt, 1);
            chk({tag, "_err_idle"}, busy_low, 2);
            chk({tag, "_err_flag"}, re, 1);
            chk({tag, "_err_bit"}, rb, 0);
            chk({tag, "_err_tie"}, rt, 0);
        end else if (abort_at > 0) begin
            chk({tag, "_abort_rv"}, rv_cnt, 0);
            chk({tag, "_abort_idle"}, busy_low, abort_at + 1);
        end else begin
            chk({tag, "_rv_cyc"}, rv_cyc, SETL + GATE + 1);
            chk({tag, "_rv_cnt"}, rv_cnt, 1);
            chk({tag, "_idle"}, busy_low, SETL + GATE + 2);
            chk({tag, "_bit"}, rb, (h[a[2:0]] < h[b[2:0]]) ? 1 : 0);
            chk({tag, "_tie"}, rt, (h[a[2:0]] == h[b[2:0]]) ? 1 : 0);
            chk({tag, "_err"}, re, 0);
            chk({tag, "_cnt_a"}, cnt_ok(int'(ca), h[a[2:0]]), 1);
            chk({tag, "_cnt_b"}, cnt_ok(int'(cb), h[b[2:0]]), 1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] a, b;
        bit got;
        i1.start = 1'b0; i1.abort = 1'b0; i1.chal_a = '0; i1.chal_b = '0;
        i2.start = 1'b0; i2.abort = 1'b0; i2.chal_a = '0; i2.chal_b = '0;
        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk("rst_ro_en", ro_en, 0);
        chk("rst_busy", i1.busy, 0);
        chk("rst_rv", i1.resp_valid, 0);
        chk("rst_cnt_a", i1.cnt_a, 0);
        @(posedge core_clk); #1;
        arst_n = 1'b1;
        @(posedge core_clk); #1;

        h[2] = 2; h[5] = 4; h[3] = 2;
        check_eval("nominal", 4'd2, 4'd5, 0, 1'b0);
        check_eval("swap", 4'd5, 4'd2, 0, 1'b0);
        check_eval("equal", 4'd2, 4'd3, 0, 1'b0);
        check_eval("bad_same", 4'd3, 4'd3, 0, 1'b0);
        check_eval("bad_range", 4'd9, 4'd2, 0, 1'b0);
        check_eval("abort", 4'd2, 4'd5, 30, 1'b0);

        check_eval("hold", 4'd2, 4'd5, 0, 1'b1);
        @(negedge core_clk);
        chk("hold_reaccept", i1.busy, 1);
        i1.start = 1'b0;
        @(posedge core_clk); #1;
        i1.abort = 1'b1;
        @(posedge core_clk); #1;
        i1.abort = 1'b0;
        @(negedge core_clk);
        chk("hold_abort_idle", i1.busy, 0);
        chk("hold_abort_en", ro_en, 0);
        @(posedge core_clk); #1;

        i1.chal_a = 4'd2; i1.chal_b = 4'd5; i1.start = 1'b1;
        @(posedge core_clk); #1;
        i1.start = 1'b0;
        repeat (39) begin
            @(posedge core_clk); #1;
        end
        @(negedge core_clk);
        chk("pre_rst_en", ro_en, 8'h24);
        #1 arst_n = 1'b0;
        #1;
        chk("async_rst_en", ro_en, 0);
        chk("async_rst_busy", i1.busy, 0);
        chk("async_rst_rv", i1.resp_valid, 0);
        chk("async_rst_cnt", i1.cnt_a, 0);
        chk("async_rst_bit", i1.resp_bit, 0);
        @(posedge core_clk); #1;
        arst_n = 1'b1;
        @(posedge core_clk); #1;
        check_eval("post_rst", 4'd2, 4'd5, 0, 1'b0);

        for (int n = 0; n < 10; n++) begin
            a = 4'($urandom_range(0, 7));
            b = 4'($urandom_range(0, 7));
            if ($urandom_range(0, 7) == 0) a = 4'($urandom_range(8, 15));
            if (a < 4'd8) h[a[2:0]] = hset[$urandom_range(0, 3)];
            h[b[2:0]] = hset[$urandom_range(0, 3)];
            check_eval("rnd", a, b, 0, 1'b0);
        end

        i2.chal_a = 3'd0; i2.chal_b = 3'd1; i2.start = 1'b1;
        @(posedge core_clk); #1;
        i2.start = 1'b0;
        @(negedge core_clk);
        chk("sat_en", ro_en2, 8'h03);
        got = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            @(posedge core_clk); #1;
            @(negedge core_clk);
            if (i2.resp_valid) begin
                got = 1'b1;
                break;
            end
        end
        chk("sat_seen", got, 1);
        chk("sat_cnt_a", i2.cnt_a, 15);
        chk("sat_cnt_b", i2.cnt_b, 15);
        chk("sat_tie", i2.resp_tie, 1);
        chk("sat_bit", i2.resp_bit, 0);
        @(posedge core_clk); #1;

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
